lab3_input_conditioner: RTL
===========================

Name: lab3_input_conditioner

Overview:
- Upstream stage of the LAB3 NAND/NOR/MUX datapath; sits between board switches and its I0..I5 / SEL0 inputs.
- Synchronises seven raw asynchronous switch lines and debounces each independently.
- Presents clean, stable levels to the combinational stage and flags every committed change with a one-cycle pulse plus per-bit mask.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per bit (legal: >=2)
- DEBOUNCE_CYCLES, 16, consecutive differing cycles required to commit a change (legal: >=2)

Ports:
- CLK  input  1  system clock, all state on rising edge
- RST_N  input  1  asynchronous active-low reset
- SW_RAW  input  7  raw switches; [5:0] map to I0..I5, [6] maps to SEL0
- HOLD  input  1  synchronous freeze of committed outputs
- I_OUT  output  6  debounced I0..I5 to LAB3 datapath
- SEL_OUT  output  1  debounced SEL0 to LAB3 datapath
- CHANGED  output  1  one-cycle pulse, some bit committed a new value
- CHANGED_MASK  output  7  bits committed on the same edge as CHANGED; zero otherwise

Behaviour:
- Reset (RST_N low, asynchronous): all synchroniser flops, stable registers, counters, I_OUT, SEL_OUT, CHANGED, CHANGED_MASK = 0. Reset mid-count discards any pending change. Deassertion is not internally synchronised; integration provides a synchronous release.
- Per bit b, identical and independent:
  - synced[b] is the last synchroniser stage.
  - Counter width = clog2(DEBOUNCE_CYCLES).
  - HOLD=0, synced==stable: counter <= 0.
  - HOLD=0, synced!=stable, counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - HOLD=0, synced!=stable, counter == DEBOUNCE_CYCLES-1: stable <= synced, counter <= 0, mask bit set this edge.
  - HOLD=1: stable unchanged, counter <= 0, no commits.
- Glitch rule: a single cycle of synced==stable restarts the count from 0. A pulse shorter than DEBOUNCE_CYCLES synced cycles never reaches the outputs.
- Latency: SW_RAW changes and stays constant from before edge 1. The output updates on edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 18 at defaults) and is visible in the following cycle.
- CHANGED / CHANGED_MASK are registered on the commit edge and hold for exactly one cycle. Simultaneous commits of several bits give one CHANGED pulse with all their bits set in the mask.
- Back-to-back commits on the same bit are impossible: after a commit, the earliest next commit is DEBOUNCE_CYCLES edges later.
- Releasing HOLD: counting restarts from 0, so a change pending during HOLD commits DEBOUNCE_CYCLES edges after HOLD falls, provided synced still differs.
- Outputs are direct from flops; no combinational path from SW_RAW or HOLD to any output.

Decomposition:
- Shared package holds:
  - NUM_SW = 7
  - index constants SEL_IDX = 6, I_LSB = 0, I_MSB = 5
  - function clog2 for counter sizing
- One sub-module is natural: sw_debounce_bit. It contains the synchroniser chain, counter and stable register for one line, with outputs stable and commit. The top instantiates 7 copies, assembles CHANGED_MASK from the commit outputs and registers CHANGED as the OR of the commits.

Test Plan:
- Reset: RST_N=0 with SW_RAW=7'h7F, then release. All outputs stay 0 until edge 18; then I_OUT=6'h3F, SEL_OUT=1, CHANGED=1 for one cycle, CHANGED_MASK=7'h7F.
- Latency: from all-zero state, raise SW_RAW[2] only. I_OUT[2] rises after edge 18 (not 17). CHANGED_MASK=7'h04 for one cycle.
- Bounce: toggle SW_RAW[0] high 10 cycles, low 1 cycle, high again. The commit occurs 18 edges after the final rise; the 10-cycle burst alone produces no change.
- Short glitch: SW_RAW[6] high for 5 cycles, then low. SEL_OUT stays 0 and CHANGED never asserts.
- HOLD: assert HOLD, set SW_RAW=7'h15 for 40 cycles. Outputs unchanged. Drop HOLD: commit on the 16th edge after release, I_OUT=6'h15, SEL_OUT=0, mask 7'h15.
- Mid-count reset: raise SW_RAW[4] and pulse RST_N low at edge 10 for 1 cycle. Outputs stay 0, and the commit then needs a full 18 edges after release.

Source files
------------

// File: rtl/lab3_input_conditioner_pkg.sv
// Shared constants and helpers for the LAB3 switch input conditioner.
// Provides switch count, index map onto I0..I5 / SEL0, and a clog2 for sizing.
package lab3_input_conditioner_pkg;

  localparam int unsigned NUM_SW  = 7;
  localparam int unsigned SEL_IDX = 6;
  localparam int unsigned I_LSB   = 0;
  localparam int unsigned I_MSB   = 5;

  // Bits needed to hold values 0..v-1 (v >= 2).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lab3_input_conditioner_debounce_bit.sv
// One switch line: synchroniser chain, debounce counter and stable register.
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   raw_i       raw asynchronous switch level
//   hold_i      freeze stable level and clear the counter
//   stable_o    debounced level (flop output)
//   commit_c_o  combinational: stable_o takes a new value on this edge
module sw_debounce_bit
  import lab3_input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic hold_i,
  output logic stable_o,
  output logic commit_c_o
);

  localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   synced;
  logic                   commit;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; bit 0 is the metastability-exposed stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  // Count consecutive differing cycles; any agreeing cycle or HOLD restarts.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    commit   = 1'b0;
    if (hold_i) begin
      cnt_d = '0;
    end else if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = synced;
      cnt_d    = '0;
      commit   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o   = stable_q;
  assign commit_c_o = commit;

endmodule

// File: rtl/lab3_input_conditioner.sv
// Synchronises and debounces the seven LAB3 switch lines.
// Ports:
//   CLK           system clock
//   RST_N         asynchronous active-low reset
//   SW_RAW[6:0]   raw switches; [5:0] -> I0..I5, [6] -> SEL0
//   HOLD          freeze committed outputs, counters held at zero
//   I_OUT[5:0]    debounced I0..I5
//   SEL_OUT       debounced SEL0
//   CHANGED       one-cycle pulse when any bit commits
//   CHANGED_MASK  bits committed on that edge, zero otherwise
module lab3_input_conditioner
  import lab3_input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_SW-1:0] SW_RAW,
  input  logic              HOLD,
  output logic [5:0]        I_OUT,
  output logic              SEL_OUT,
  output logic              CHANGED,
  output logic [NUM_SW-1:0] CHANGED_MASK
);

  logic [NUM_SW-1:0] stable;
  logic [NUM_SW-1:0] commit_c;
  logic              changed_q;
  logic [NUM_SW-1:0] changed_mask_q;

  for (genvar b = 0; b < NUM_SW; b++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .raw_i      (SW_RAW[b]),
      .hold_i     (HOLD),
      .stable_o   (stable[b]),
      .commit_c_o (commit_c[b])
    );
  end

  // Change flags are captured on the same edge the stable bits update.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      changed_q      <= 1'b0;
      changed_mask_q <= '0;
    end else begin
      changed_q      <= |commit_c;
      changed_mask_q <= commit_c;
    end
  end

  assign I_OUT        = stable[I_MSB:I_LSB];
  assign SEL_OUT      = stable[SEL_IDX];
  assign CHANGED      = changed_q;
  assign CHANGED_MASK = changed_mask_q;

endmodule
